seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
Stream controller for the bit-serial '1011'-class pattern detector. Accepts parallel words over a valid/ready handshake and serializes them MSB-first, one bit per clock. Runs a programmable, overlapping pattern match across the continuous bit stream, counts matches, and raises a sticky threshold interrupt. Sits between a parallel data source or bus and the serial detection and reporting logic.

Parameters:
DW, 8, input word width (>=2)
PW, 4, pattern length in bits (2..DW)
PATTERN, 4'b1011, match pattern; MSB is the first bit in time
CW, 8, match counter width

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_en  in  1  enable accepting new words
i_clr  in  1  synchronous clear of count, irq, history
i_data  in  DW  parallel word
i_valid  in  1  i_data valid
o_ready  out  1  controller can accept a word this cycle
o_bit  out  1  current serial bit
o_bit_vld  out  1  o_bit valid
o_match  out  1  one-cycle match pulse
o_cnt  out  CW  match count, saturating
i_thresh  in  CW  interrupt threshold; 0 disables irq
o_irq  out  1  sticky threshold interrupt
o_busy  out  1  word being shifted

Behaviour:
- Clock and reset: single clock i_clk; reset is asynchronous, active-low, on i_rstn.
- Reset values: state S_IDLE; o_bit=0, o_bit_vld=0, o_match=0, o_cnt=0, o_irq=0, o_busy=0. Shift register, bit counter, history and fill counter all cleared.
- FSM states: S_IDLE, S_SHIFT.
  - S_IDLE: o_ready=i_en. A handshake (i_valid & o_ready) at edge k loads the shift register, sets bitcnt=0, goes to S_SHIFT.
  - S_SHIFT: o_busy=1, o_bit_vld=1, o_bit=shreg[DW-1]. The register shifts left each edge; bitcnt increments.
- Latency and ordering: after a handshake at edge k, bits i_data[DW-1]..i_data[0] appear in cycles k+1..k+DW.
- Back-to-back: in the last shift cycle (bitcnt==DW-1), o_ready=i_en. A handshake then reloads and stays in S_SHIFT, so there is no bubble. Otherwise the FSM returns to S_IDLE.
- i_en deasserted mid-word: the current word completes; no new word is accepted.
- o_ready is combinational from state, bitcnt and i_en; it does not depend on i_valid.
- Match history:
  - PW-1 bit history register persists across word boundaries, so matches may span words.
  - Fill counter saturates at PW-1; no match is possible until PW valid bits have been seen since reset or clear.
  - Match condition: fill complete and {history, o_bit}==PATTERN while o_bit_vld=1. Overlapping matches count.
- o_match is registered: it pulses high in the cycle after the completing bit.
- o_cnt increments on the same edge that raises o_match and saturates at 2^CW-1.
- o_irq sets at the edge where the new o_cnt >= i_thresh with i_thresh!=0. It stays set until i_clr or reset.
- i_clr:
  - Next edge: o_cnt=0, o_irq=0, history and fill counter cleared, o_match=0.
  - A match on the same edge is discarded, since clr wins.
  - Does not abort the word in flight; its remaining bits feed the fresh history.
- Reset asserted mid-word: immediate return to reset values; the partial word is lost.

Test Plan:
1. Reset, then word 8'b1011_0110 with thresh=0 -> bits 1,0,1,1,0,1,1,0 in cycles k+1..k+8; o_match pulses in cycles k+5 and k+8; o_cnt=2; o_irq stays 0.
2. Cross-word match: 8'h05 then 8'h80 back-to-back with i_valid held high -> second handshake in cycle k+8; o_bit_vld high continuously for 16 cycles; exactly one match, pulsing in cycle k+10 (one cycle after bit 1 of the second word); o_cnt=1.
3. Threshold: i_thresh=3; send 8'b1011_0110 then 8'b1011_0000 -> o_cnt goes 1,2,3; o_irq rises on the edge where o_cnt reaches 3 and stays set; i_clr then gives o_cnt=0 and o_irq=0 on the next edge.
4. Clear collision: assert i_clr in the same cycle as a completing bit -> no o_match pulse, o_cnt=0; the fill requirement restarts, so a '011' immediately after does not match.
5. Flow control: i_en=0 during a word -> the word finishes its 8 bits, o_ready stays 0, the FSM idles; re-assert i_en -> o_ready=1 the same cycle.
6. Reset mid-shift at bit 4 -> all outputs 0 immediately, asynchronously; after release o_ready=i_en, and the next word is detected with no stale history.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit serializer with an overlapping pattern matcher, saturating match
// counter and sticky threshold interrupt.
module seq_detect_ctrl #(
  parameter int              DW      = 8,
  parameter int              PW      = 4,
  parameter logic [PW-1:0]   PATTERN = 4'b1011,
  parameter int              CW      = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic          o_bit,
  output logic          o_bit_vld,
  output logic          o_match,
  output logic [CW-1:0] o_cnt,
  input  logic [CW-1:0] i_thresh,
  output logic          o_irq,
  output logic          o_busy
);

  localparam int             BW   = $clog2(DW);
  localparam int             FW   = $clog2(PW);
  localparam logic [BW-1:0]  LAST = BW'(DW - 1);
  localparam logic [FW-1:0]  FULL = FW'(PW - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  state_t          state, state_nxt;
  logic [DW-1:0]   shreg, shreg_nxt;
  logic [BW-1:0]   bitcnt, bitcnt_nxt;
  logic [PW-2:0]   hist;
  logic [FW-1:0]   fill;
  logic [PW-1:0]   window;
  logic            match_now;
  logic [CW-1:0]   cnt_nxt;
  logic            irq_hit;

  // serializer: state, shift register and bit counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= S_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      bitcnt <= bitcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    o_ready    = 1'b0;
    o_busy     = 1'b0;
    o_bit_vld  = 1'b0;
    o_bit      = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = i_en;
        if (i_valid && i_en) begin
          shreg_nxt  = i_data;
          bitcnt_nxt = '0;
          state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        o_busy    = 1'b1;
        o_bit_vld = 1'b1;
        o_bit     = shreg[DW-1];
        // the last bit cycle doubles as the accept slot, so words stream gap-free
        o_ready   = i_en && (bitcnt == LAST);
        if (bitcnt == LAST) begin
          if (i_valid && i_en) begin
            shreg_nxt  = i_data;
            bitcnt_nxt = '0;
          end else begin
            shreg_nxt  = {shreg[DW-2:0], 1'b0};
            state_nxt  = S_IDLE;
          end
        end else begin
          shreg_nxt  = {shreg[DW-2:0], 1'b0};
          bitcnt_nxt = bitcnt + BW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // matcher: history spans word boundaries; no match until PW bits seen
  always_comb begin
    window    = {hist, o_bit};
    match_now = o_bit_vld && (fill == FULL) && (window == PATTERN);
    cnt_nxt   = match_now ? sat_inc(o_cnt) : o_cnt;
    irq_hit   = (i_thresh != '0) && (cnt_nxt >= i_thresh);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hist    <= '0;
      fill    <= '0;
      o_match <= 1'b0;
      o_cnt   <= '0;
      o_irq   <= 1'b0;
    end else if (i_clr) begin
      hist    <= '0;
      fill    <= '0;
      o_match <= 1'b0;
      o_cnt   <= '0;
      o_irq   <= 1'b0;
    end else begin
      o_match <= match_now;
      o_cnt   <= cnt_nxt;
      if (irq_hit) o_irq <= 1'b1;
      if (o_bit_vld) begin
        hist <= window[PW-2:0];
        if (fill != FULL) fill <= fill + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: per-cycle vector table plus hand-written
// asynchronous-reset sequence.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en, clr, valid;
  logic [7:0] data, thresh;
  logic       ready, sbit, bit_vld, match, irq, busy;
  logic [7:0] cnt;

  int checks = 0;
  int errors = 0;

  seq_detect_ctrl #(.DW(8), .PW(4), .PATTERN(4'b1011), .CW(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_clr(clr), .i_data(data),
    .i_valid(valid), .o_ready(ready), .o_bit(sbit), .o_bit_vld(bit_vld),
    .o_match(match), .o_cnt(cnt), .i_thresh(thresh), .o_irq(irq), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, clr, valid;
    logic [7:0] data, thr;
    logic       rdy, sb, vld, m;
    logic [7:0] cnt;
    logic       irq, busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int a_en, a_clr, a_valid, a_data, a_thr,
                     input int a_rdy, a_sb, a_vld, a_m, a_cnt, a_irq, a_busy);
    vec_t v;
    v.en = a_en[0]; v.clr = a_clr[0]; v.valid = a_valid[0];
    v.data = a_data[7:0]; v.thr = a_thr[7:0];
    v.rdy = a_rdy[0]; v.sb = a_sb[0]; v.vld = a_vld[0]; v.m = a_m[0];
    v.cnt = a_cnt[7:0]; v.irq = a_irq[0]; v.busy = a_busy[0];
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  w;
    logic [15:0] s;
    logic [13:0] act, exp;
    logic        seen;

    rstn = 1'b0; en = 1'b0; clr = 1'b0; valid = 1'b0; data = '0; thresh = '0;
    #3;
    chk("reset_outputs", {26'd0, sbit, bit_vld, match, irq, busy, ready}, 32'd0);
    chk("reset_cnt", {24'd0, cnt}, 32'd0);
    en = 1'b1;
    #1;
    chk("reset_ready_follows_en", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b1;

    // single word 1011_0110, matches complete at bits 4 and 7
    w = 8'hB6;
    add(1,0,1,8'hB6,0, 1,0,0,0,0,0,0);
    for (int i = 1; i <= 8; i++)
      add(1,0,0,0,0, int'(i==8), int'(w[8-i]), 1, int'(i==5 || i==8),
          (i < 5) ? 0 : (i < 8) ? 1 : 2, 0, 1);
    add(1,0,0,0,0, 1,0,0,0,2,0,0);
    add(1,1,0,0,0, 1,0,0,0,2,0,0);

    // 05 then 80 back-to-back, one match straddling the boundary
    s = 16'h0580;
    add(1,0,1,8'h05,0, 1,0,0,0,0,0,0);
    for (int i = 1; i <= 16; i++)
      add(1,0,int'(i<=8),8'h80,0, int'(i==8 || i==16), int'(s[16-i]), 1,
          int'(i==10), int'(i>=10), 0, 1);
    add(1,0,0,0,0, 1,0,0,0,1,0,0);

    // threshold 3 with B6 then B0
    add(1,1,0,0,3, 1,0,0,0,1,0,0);
    s = 16'hB6B0;
    add(1,0,1,8'hB6,3, 1,0,0,0,0,0,0);
    for (int i = 1; i <= 16; i++)
      add(1,0,int'(i<=8),8'hB0,3, int'(i==8 || i==16), int'(s[16-i]), 1,
          int'(i==5 || i==8 || i==13),
          (i < 5) ? 0 : (i < 8) ? 1 : (i < 13) ? 2 : 3, int'(i>=13), 1);
    add(1,0,0,0,3, 1,0,0,0,3,1,0);
    add(1,1,0,0,3, 1,0,0,0,3,1,0);
    add(1,0,0,0,3, 1,0,0,0,0,0,0);

    // clear on the completing bit: match discarded, fill restarts
    w = 8'hB6;
    add(1,0,1,8'hB6,0, 1,0,0,0,0,0,0);
    for (int i = 1; i <= 8; i++)
      add(1,int'(i==4),0,0,0, int'(i==8), int'(w[8-i]), 1, 0, 0, 0, 1);
    add(1,0,0,0,0, 1,0,0,0,0,0,0);

    // enable dropped mid-word: word completes, nothing new accepted
    add(1,0,1,0,0, 1,0,0,0,0,0,0);
    for (int i = 1; i <= 8; i++)
      add(0,0,1,0,0, 0,0,1,0,0,0,1);
    add(0,0,1,0,0, 0,0,0,0,0,0,0);
    add(1,0,0,0,0, 1,0,0,0,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      en = vq[i].en; clr = vq[i].clr; valid = vq[i].valid;
      data = vq[i].data; thresh = vq[i].thr;
      @(negedge clk);
      act = {ready, sbit, bit_vld, match, cnt, irq, busy};
      exp = {vq[i].rdy, vq[i].sb, vq[i].vld, vq[i].m, vq[i].cnt, vq[i].irq, vq[i].busy};
      chk($sformatf("vec%0d rdy.bit.vld.match.cnt.irq.busy", i), {18'd0, act}, {18'd0, exp});
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of a word, history primed with 101
    en = 1'b1; clr = 1'b0; thresh = '0; valid = 1'b1; data = 8'hB6;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_shifting", {30'd0, sbit, bit_vld}, 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", {26'd0, sbit, bit_vld, match, irq, busy, cnt != 8'd0}, 32'd0);
    chk("async_reset_ready", {31'd0, ready}, 32'd1);
    en = 1'b0;
    #1;
    chk("reset_ready_low_en", {31'd0, ready}, 32'd0);
    en = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    valid = 1'b1; data = 8'hC0;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    w = 8'hC0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (match) seen = 1'b1;
      if (i < 8) chk($sformatf("post_reset_bit%0d", i), {31'd0, sbit}, {31'd0, w[7-i]});
      @(posedge clk); #1;
    end
    chk("no_stale_history", {23'd0, seen, cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
